// File: rtl/stage4_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : stage4_mem_pkg
// Description : Shared constants for the memory-access stage. Holds the bus
//               widths, the bit offsets of the execute-to-memory bus fields
//               and the load-operation encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package stage4_mem_pkg;

    // Bus widths
    localparam int c_WIDTH_ES_TO_MS_BUS = 74;
    localparam int c_WIDTH_MS_TO_WS_BUS = 70;
    localparam int c_WIDTH_MS_TO_DS_BUS = 38;

    // Field offsets inside the execute-to-memory bus
    localparam int c_ES_PC_LSB       = 0;
    localparam int c_ES_GR_WE        = 32;
    localparam int c_ES_RES_FROM_MEM = 33;
    localparam int c_ES_DEST_LSB     = 34;
    localparam int c_ES_ALU_LSB      = 39;
    localparam int c_ES_LD_OP_LSB    = 71;

    // Load operation encodings; bit 2 selects zero extension
    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_B  = 3'b001,
        LD_H  = 3'b010,
        LD_BU = 3'b101,
        LD_HU = 3'b110
    } ld_op_e;

endpackage : stage4_mem_pkg
`default_nettype wire

// File: rtl/stage4_mem_load_align.sv
`default_nettype none
// ============================================================================
// Module      : stage4_mem_load_align
// Description : Combinational load-data aligner. Picks the byte or halfword
//               lane addressed by addr[1:0] and sign- or zero-extends it.
//               Unknown operation codes return the full word. addr[0] is
//               ignored for halfword loads (no misalignment trap).
// Revision    : 1.0 - initial release
// ============================================================================
module stage4_mem_load_align
    import stage4_mem_pkg::*;
(
    input  logic [2:0]  ld_op,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection and extension
    always_comb begin
        w_byte = rdata[7:0];
        w_half = addr[1] ? rdata[31:16] : rdata[15:0];
        result = rdata;
        case (addr)
            2'b00:   w_byte = rdata[7:0];
            2'b01:   w_byte = rdata[15:8];
            2'b10:   w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        case (ld_op)
            LD_B:    result = {{24{w_byte[7]}}, w_byte};
            LD_BU:   result = {24'h0, w_byte};
            LD_H:    result = {{16{w_half[15]}}, w_half};
            LD_HU:   result = {16'h0, w_half};
            default: result = rdata;
        endcase
    end

endmodule : stage4_mem_load_align
`default_nettype wire

// File: rtl/stage4_mem.sv
`default_nettype none
// ============================================================================
// Module      : stage4_mem
// Description : Memory-access pipeline stage. Registers the execute bus,
//               captures the synchronous data-SRAM response, aligns load
//               data and forwards {we, dest, result} to decode.
//               Build option MS_LOAD_EXT_EN enables byte/halfword loads;
//               without it every load returns the full word.
// Revision    : 1.0 - initial release
// ============================================================================
module stage4_mem
    import stage4_mem_pkg::*;
#(
    parameter int WIDTH_ES_TO_MS_BUS = c_WIDTH_ES_TO_MS_BUS,
    parameter int WIDTH_MS_TO_WS_BUS = c_WIDTH_MS_TO_WS_BUS,
    parameter int WIDTH_MS_TO_DS_BUS = c_WIDTH_MS_TO_DS_BUS
)
(
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ws_allow_in,
    output logic                          ms_allow_in,
    input  logic                          es_to_ms_valid,
    output logic                          ms_to_ws_valid,
    input  logic [WIDTH_ES_TO_MS_BUS-1:0] es_to_ms_bus,
    input  logic [31:0]                   data_sram_rdata,
    output logic [WIDTH_MS_TO_WS_BUS-1:0] ms_to_ws_bus,
    output logic [WIDTH_MS_TO_DS_BUS-1:0] ms_to_ds_bus
);

    logic                          r_ms_valid;
    logic [WIDTH_ES_TO_MS_BUS-1:0] r_bus;
    logic                          r_fresh;
    logic [31:0]                   r_rdata_hold;

    logic        w_ms_ready_go;
    logic        w_accept;
    logic [31:0] w_pc;
    logic        w_gr_we;
    logic        w_res_from_mem;
    logic [4:0]  w_dest;
    logic [31:0] w_alu_result;
    logic [31:0] w_eff_rdata;
    logic [31:0] w_load_data;
    logic [31:0] w_final_result;

    // The stage never waits on anything internal
    assign w_ms_ready_go  = 1'b1;
    assign ms_allow_in    = !r_ms_valid || (w_ms_ready_go && ws_allow_in);
    assign ms_to_ws_valid = r_ms_valid && w_ms_ready_go;
    assign w_accept       = es_to_ms_valid && ms_allow_in;

    // Valid flag, bus register and response capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid   <= 1'b0;
            r_bus        <= '0;
            r_fresh      <= 1'b0;
            r_rdata_hold <= 32'h0;
        end else begin
            if (ms_allow_in) begin
                r_ms_valid <= es_to_ms_valid;
            end
            if (w_accept) begin
                r_bus <= es_to_ms_bus;
            end
            // The SRAM output is only trustworthy in the first resident
            // cycle; keep a copy so stalls do not see a later response.
            r_fresh <= w_accept;
            if (r_fresh && r_ms_valid) begin
                r_rdata_hold <= data_sram_rdata;
            end
        end
    end

    assign w_pc           = r_bus[c_ES_PC_LSB +: 32];
    assign w_gr_we        = r_bus[c_ES_GR_WE];
    assign w_res_from_mem = r_bus[c_ES_RES_FROM_MEM];
    assign w_dest         = r_bus[c_ES_DEST_LSB +: 5];
    assign w_alu_result   = r_bus[c_ES_ALU_LSB +: 32];
    assign w_eff_rdata    = r_fresh ? data_sram_rdata : r_rdata_hold;

`ifdef MS_LOAD_EXT_EN
    stage4_mem_load_align u_load_align (
        .ld_op  (r_bus[c_ES_LD_OP_LSB +: 3]),
        .addr   (w_alu_result[1:0]),
        .rdata  (w_eff_rdata),
        .result (w_load_data)
    );
`else
    // Word-only build: the operation field is carried but not decoded
    logic w_unused_ld_op;
    assign w_unused_ld_op = ^r_bus[c_ES_LD_OP_LSB +: 3];
    assign w_load_data    = w_eff_rdata;
`endif

    assign w_final_result = w_res_from_mem ? w_load_data : w_alu_result;
    assign ms_to_ws_bus   = {w_final_result, w_dest, w_gr_we, w_pc};
    assign ms_to_ds_bus   = {w_gr_we & r_ms_valid, w_dest, w_final_result};

endmodule : stage4_mem
`default_nettype wire
